dl_pack_rom: RTL
================

DL_PACK_ROM -- requirements
Module: dl_pack_rom

Interface
REQ-001 Parameter AW, default 12: word-address width of the storage array (2**AW words).
REQ-002 Parameter BPW, default 2: bytes per word; legal values 1, 2 and 4; data width DW = 8*BPW.
REQ-003 Parameter BASE, default 17'h11000: first download byte address owned by this block.
REQ-004 I_CLK  input  1  single clock for download, storage and read; all logic rising-edge.
REQ-005 I_RST_N  input  1  asynchronous, active-low reset.
REQ-006 I_DLADDR  input  17  download byte address.
REQ-007 I_DLDATA  input  8  download byte.
REQ-008 I_DLWR  input  1  download byte strobe, one byte per asserted cycle.
REQ-009 I_ADDR  input  AW  read word address.
REQ-010 I_CE_N  input  1  active-low read enable.
REQ-011 O_DATA  output  DW  registered read data, little-endian (lane 0 in bits 7:0).
REQ-012 O_WCOUNT  output  AW+1  count of words committed since reset, saturating at 2**AW.
REQ-013 O_CKSUM  output  16  modulo-2**16 sum of all accepted bytes.
REQ-014 O_DONE  output  1  sticky: word 2**AW-1 committed.
REQ-015 O_ERR  output  1  sticky: packing sequence violation detected.

Function
REQ-016 In-region byte: I_DLWR=1 and BASE <= I_DLADDR < BASE + BPW*2**AW; out-of-region strobes SHALL be ignored entirely (no state, checksum or flag change).
REQ-017 Offset = I_DLADDR - BASE; lane = offset mod BPW; word address = offset / BPW (truncated to AW bits).
REQ-018 Packer FSM states: IDLE (no partial word), FILL (lanes 0..n-1 held for word W, next expected lane n).
REQ-019 IDLE + lane 0 byte -> latch byte into lane 0 and W; go to FILL (or commit immediately when BPW=1).
REQ-020 FILL + byte with same W and lane = expected lane -> latch byte; when lane = BPW-1, commit and return to IDLE.
REQ-021 Commit: full DW word written to array[W] on the clock edge after the final lane is accepted; O_WCOUNT increments on that same edge.
REQ-022 Sequence violation (IDLE + lane≠0, or FILL + wrong lane or different W) SHALL set O_ERR and discard the partial word; if the violating byte is lane 0 it SHALL start a new word (FILL), otherwise FSM goes to IDLE.
REQ-023 Every in-region byte that is latched into a lane (accepted) SHALL be added to O_CKSUM in the cycle it is strobed; discarded/violating non-lane-0 bytes SHALL NOT be added.
REQ-024 O_DONE sets on the commit edge of word address 2**AW-1 and holds until reset; further downloads after O_DONE SHALL still be accepted (reload allowed).
REQ-025 Read: O_DATA SHALL update one clock after I_ADDR is presented with I_CE_N=0; with I_CE_N=1 O_DATA SHALL register 0.
REQ-026 Simultaneous read and commit to the same word SHALL return the pre-commit (old) contents; the new value is visible on the next read.
REQ-027 O_WCOUNT counts commits (including rewrites of the same word) and SHALL saturate at 2**AW, never wrap.
REQ-028 O_CKSUM SHALL wrap modulo 2**16.

Reset
REQ-029 While I_RST_N=0: FSM=IDLE, partial word cleared, O_DATA=0, O_WCOUNT=0, O_CKSUM=0, O_DONE=0, O_ERR=0.
REQ-030 Reset asserted mid-word SHALL discard the partial word with no commit; array contents SHALL NOT be cleared by reset.
REQ-031 First download byte after reset release SHALL be processed normally in the first cycle I_RST_N=1.

Verification
REQ-032 BPW=2, BASE=17'h11000: bytes 34h@11000, 12h@11001 -> array[0]=1234h one cycle later, O_WCOUNT=1, O_CKSUM=0046h; read addr 0 -> O_DATA=1234h next cycle.
REQ-033 Strobe at 17'h10FFF and 17'h13000 (AW=12, BPW=2) -> no change to any output or array.
REQ-034 Bytes lane0@11002 then lane0@11004 -> O_ERR=1, word 1 never written, FSM in FILL for word 2; completing 11005 commits word 2.
REQ-035 Full sequential load 8192 bytes AW=12 BPW=2 -> O_DONE=1 after final commit, O_WCOUNT=4096, O_CKSUM = byte sum mod 65536, O_ERR=0.
REQ-036 Read word 5 on the same edge it commits new data -> O_DATA shows old value; next read shows new value.
REQ-037 Assert I_RST_N=0 between lane 0 and lane 1 -> all outputs 0, word untouched, previously committed words still readable after release.

Source files
------------

// File: rtl/dl_pack_rom.sv
// Download-fed packed ROM: gathers little-endian byte lanes from a download
// stream into words, commits them to a storage array and serves registered reads.
module dl_pack_rom #(
  parameter int          AW   = 12,
  parameter int          BPW  = 2,
  parameter logic [16:0] BASE = 17'h11000
) (
  input  logic              I_CLK,
  input  logic              I_RST_N,
  input  logic [16:0]       I_DLADDR,
  input  logic [7:0]        I_DLDATA,
  input  logic              I_DLWR,
  input  logic [AW-1:0]     I_ADDR,
  input  logic              I_CE_N,
  output logic [8*BPW-1:0]  O_DATA,
  output logic [AW:0]       O_WCOUNT,
  output logic [15:0]       O_CKSUM,
  output logic              O_DONE,
  output logic              O_ERR
);

  localparam int          DW        = 8 * BPW;
  localparam int          SH        = $clog2(BPW);
  localparam int          LW        = (SH > 0) ? SH : 1;
  localparam int          DEPTH     = 1 << AW;
  localparam logic [31:0] REGION_LO = 32'(BASE);
  localparam logic [31:0] REGION_HI = 32'(BASE) + 32'(BPW * DEPTH);
  localparam logic [AW:0] WMAX      = (AW + 1)'(DEPTH);
  localparam logic [AW-1:0] LAST_WORD = '1;
  localparam logic [LW-1:0] LAST_LANE = LW'(BPW - 1);

  typedef enum logic {
    IDLE,
    FILL
  } state_t;

  state_t          state, state_n;
  logic [AW-1:0]   cur_word, word_n;
  logic [LW-1:0]   exp_lane, lane_n;
  logic [DW-1:0]   part_buf, buf_n;
  logic [DW-1:0]   mem [DEPTH];

  logic [31:0]     addr_ext;
  logic [16:0]     offset;
  logic [AW-1:0]   byte_word;
  logic [LW-1:0]   byte_lane;
  logic            in_region;
  logic            accept;
  logic            commit;
  logic            violation;
  logic            start;

  // Reset gates the strobe so nothing can commit while the block is held in reset.
  assign addr_ext  = {15'd0, I_DLADDR};
  assign in_region = I_RST_N && I_DLWR && (addr_ext >= REGION_LO) && (addr_ext < REGION_HI);
  assign offset    = I_DLADDR - BASE;
  assign byte_word = AW'(offset >> SH);
  assign byte_lane = LW'(offset & 17'(BPW - 1));

  always_comb begin
    state_n   = state;
    word_n    = cur_word;
    lane_n    = exp_lane;
    buf_n     = part_buf;
    accept    = 1'b0;
    commit    = 1'b0;
    violation = 1'b0;
    start     = 1'b0;
    if (in_region) begin
      case (state)
        IDLE: begin
          if (byte_lane == '0) start = 1'b1;
          else violation = 1'b1;
        end
        FILL: begin
          if ((byte_word == cur_word) && (byte_lane == exp_lane)) begin
            accept = 1'b1;
            for (int i = 0; i < BPW; i++) begin
              if (byte_lane == LW'(i)) buf_n[8*i +: 8] = I_DLDATA;
            end
            if (byte_lane == LAST_LANE) begin
              commit  = 1'b1;
              state_n = IDLE;
              lane_n  = '0;
            end else begin
              lane_n = exp_lane + 1'b1;
            end
          end else begin
            violation = 1'b1;
            if (byte_lane == '0) begin
              start = 1'b1;
            end else begin
              state_n = IDLE;
              lane_n  = '0;
            end
          end
        end
        default: state_n = IDLE;
      endcase
      // A lane-0 byte always opens a fresh word, even right after a violation.
      if (start) begin
        accept = 1'b1;
        word_n = byte_word;
        buf_n  = DW'(I_DLDATA);
        if (BPW == 1) begin
          commit  = 1'b1;
          state_n = IDLE;
          lane_n  = '0;
        end else begin
          state_n = FILL;
          lane_n  = LW'(1);
        end
      end
    end
  end

  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      state    <= IDLE;
      cur_word <= '0;
      exp_lane <= '0;
      part_buf <= '0;
      O_WCOUNT <= '0;
      O_CKSUM  <= '0;
      O_DONE   <= 1'b0;
      O_ERR    <= 1'b0;
    end else begin
      state    <= state_n;
      cur_word <= word_n;
      exp_lane <= lane_n;
      part_buf <= buf_n;
      if (commit && (O_WCOUNT != WMAX)) O_WCOUNT <= O_WCOUNT + 1'b1;
      if (accept) O_CKSUM <= O_CKSUM + {8'd0, I_DLDATA};
      if (commit && (word_n == LAST_WORD)) O_DONE <= 1'b1;
      if (violation) O_ERR <= 1'b1;
    end
  end

  // Storage is deliberately not reset so loaded contents survive a reset pulse.
  always_ff @(posedge I_CLK) begin
    if (commit) mem[word_n] <= buf_n;
  end

  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      O_DATA <= '0;
    end else if (!I_CE_N) begin
      O_DATA <= mem[I_ADDR];
    end else begin
      O_DATA <= '0;
    end
  end

endmodule
